// File: rtl/dmem_readout.sv
// -----------------------------------------------------------------------------
// dmem_readout
//
// Sequential data-memory readout engine. A start command captures a first
// word address and a word count. The engine then reads that run of words
// through a synchronous-read memory port (data returns one cycle after the
// strobe) and streams them out over a valid/ready interface. The final beat
// is marked, and an additive 32-bit checksum of every word sent is reported.
//
// Ports
//   clk, rst     system clock; synchronous active-high reset
//   start        transfer request, only honoured in IDLE
//   start_addr   first word address (captured with start)
//   word_count   number of words to read (captured with start), 0 is legal
//   abort        synchronous flush back to IDLE, suppresses done
//   busy         transfer in progress (RUN state)
//   done         one-cycle pulse after the final beat has been accepted
//   checksum     sum mod 2^32 of the words sent, held after done
//   mem_rd_en    memory read strobe
//   mem_addr     memory word address
//   mem_rdata    memory read data, valid one cycle after mem_rd_en
//   out_valid    stream beat valid
//   out_ready    stream sink ready
//   out_data     beat payload
//   out_last     final beat marker
//   out_index    0-based beat index
// -----------------------------------------------------------------------------
module dmem_readout #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic [ADDR_W:0]   out_index
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Transfer bookkeeping
  logic [ADDR_W:0]   count_q;     // words requested
  logic [ADDR_W:0]   issued_q;    // reads issued so far
  logic [ADDR_W:0]   sent_q;      // beats popped so far == index of FIFO head
  logic [ADDR_W-1:0] addr_q;      // next read address
  logic              inflight_q;  // a read was issued last cycle; data is on mem_rdata now
  logic [31:0]       sum_q;

  // Two-entry FIFO holding returned words until the sink accepts them
  logic [31:0] fifo_mem [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  fifo_cnt_q;

  logic        accept;
  logic        push;
  logic        pop;
  logic        last_pop;
  logic        reads_left;
  logic        head_last;
  logic [2:0]  occupancy;
  logic        issue;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  assign out_valid  = (fifo_cnt_q != 2'd0);
  assign pop        = out_valid & out_ready;
  assign push       = inflight_q;
  assign reads_left = (issued_q != count_q);
  assign head_last  = (sent_q == count_q - 1'b1);
  assign last_pop   = pop & head_last;

  // start and abort in the same IDLE cycle: abort wins.
  assign accept     = (state_q == S_IDLE) & start & ~abort;

  // Words buffered plus the word on its way back; a read is only issued when
  // the FIFO is guaranteed to have room for its data next cycle, counting a
  // slot freed by a pop happening this cycle.
  assign occupancy  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign issue      = (state_q == S_RUN) & reads_left & ~abort & ~rst &
                      (occupancy < (3'd2 + {2'b00, pop}));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (word_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_pop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE) & ~abort;
  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;
  assign checksum  = sum_q;

  // Beat fields are masked while the FIFO is empty so the stream reads as
  // zero after reset or a flush, whatever stale words sit in storage.
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : 32'h0;
  assign out_last  = out_valid & head_last;
  assign out_index = out_valid ? sent_q : '0;

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      sum_q      <= 32'h0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;

      if (accept) begin
        count_q  <= word_count;
        addr_q   <= start_addr;
        issued_q <= '0;
        sent_q   <= '0;
        sum_q    <= 32'h0;
      end

      // Address wraps naturally modulo 2^ADDR_W.
      if (issue) begin
        addr_q   <= addr_q + 1'b1;
        issued_q <= issued_q + 1'b1;
      end

      if (pop) begin
        sum_q  <= sum_q + out_data;
        sent_q <= sent_q + 1'b1;
      end

      if (abort) begin
        // Flush buffered words; a word returning this cycle is dropped too.
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
        fifo_cnt_q <= 2'd0;
      end else begin
        if (push) begin
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        unique case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy is tracked by fifo_cnt_q and the
    // outputs are masked when empty, so stale contents are never observed.
    if (push && !abort) begin
      fifo_mem[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_readout.sv
module tb_dmem_readout;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata = 32'h0;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic [ADDR_W:0]   out_index;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_readout #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_index  (out_index)
  );

  // Synchronous-read memory model
  logic [31:0] dmem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= dmem[mem_addr];

  // Cycle counter
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs beats, reads and done pulses; tracks protocol rules
  logic [31:0] b_data [$];
  int          b_idx  [$];
  bit          b_last [$];
  int          b_cyc  [$];
  int          r_addr [$];
  int          r_cyc  [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [31:0] done_sum = 32'h0;
  int          outst = 0;
  int          ovf_err = 0;
  int          stall_err = 0;
  int          rdout_err = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [ADDR_W:0] prev_idx;
  logic        prev_last;

  always @(negedge clk) begin
    if (prev_stall && (!out_valid || out_data !== prev_data ||
                       out_index !== prev_idx || out_last !== prev_last))
      stall_err++;
    if (mem_rd_en && !busy) rdout_err++;
    if (mem_rd_en) begin
      r_addr.push_back(int'(mem_addr));
      r_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      b_data.push_back(out_data);
      b_idx.push_back(int'(out_index));
      b_last.push_back(out_last);
      b_cyc.push_back(cyc);
    end
    outst = outst + int'(mem_rd_en) - int'(out_valid && out_ready);
    if (outst > 2) ovf_err++;
    if (!busy) outst = 0;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_sum = checksum;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_idx   = out_index;
    prev_last  = out_last;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer and waits (bounded) for done. pulse_k > 0 re-pulses
  // start with different arguments in that cycle to test it is ignored.
  task automatic run(input string tag, input int addr, input int n, input int mode,
                     input int pulse_k, output int t0, output int nb0, output int nr0,
                     output int d0);
    bit seen;
    nb0 = b_data.size();
    nr0 = r_addr.size();
    d0  = done_cnt;
    tick();
    start_addr = addr[ADDR_W-1:0];
    word_count = n[ADDR_W:0];
    start      = 1'b1;
    out_ready  = rdy(mode, 0);
    t0         = cyc;
    seen       = 1'b0;
    for (int k = 1; k < 400; k++) begin
      tick();
      start     = (k == pulse_k);
      if (k == pulse_k) begin
        start_addr = '0;
        word_count = 9'd2;
      end
      out_ready = rdy(mode, k);
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic check_run(input string tag, input int addr, input int n, input int t0,
                           input int nb0, input int nr0, input bit tight,
                           input logic [31:0] exp_sum);
    int nb;
    int nr;
    nb = b_data.size() - nb0;
    nr = r_addr.size() - nr0;
    check({tag, "_beats"}, 64'(nb), 64'(n));
    check({tag, "_reads"}, 64'(nr), 64'(n));
    for (int i = 0; i < n && i < nb; i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(b_data[nb0+i]), 64'(dmem[(addr+i) % 256]));
      check($sformatf("%s_idx%0d", tag, i), 64'(b_idx[nb0+i]), 64'(i));
      check($sformatf("%s_last%0d", tag, i), 64'(b_last[nb0+i]), 64'(i == n-1));
      if (tight) check($sformatf("%s_bcyc%0d", tag, i), 64'(b_cyc[nb0+i] - t0), 64'(i+3));
    end
    for (int i = 0; i < n && i < nr; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(r_addr[nr0+i]), 64'((addr+i) % 256));
      if (tight) check($sformatf("%s_rcyc%0d", tag, i), 64'(r_cyc[nr0+i] - t0), 64'(i+1));
    end
    check({tag, "_sum"}, 64'(done_sum), 64'(exp_sum));
    if (tight) check({tag, "_done_cyc"}, 64'(done_cyc - t0), 64'(n+3));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_done"},   64'(done), 64'd0);
    check({tag, "_valid"},  64'(out_valid), 64'd0);
    check({tag, "_last"},   64'(out_last), 64'd0);
    check({tag, "_data"},   64'(out_data), 64'd0);
    check({tag, "_index"},  64'(out_index), 64'd0);
    check({tag, "_rd_en"},  64'(mem_rd_en), 64'd0);
    check({tag, "_addr"},   64'(mem_addr), 64'd0);
    check({tag, "_sum"},    64'(checksum), 64'd0);
  endtask

  // Starts a 10-word transfer and disturbs it in cycle 5 with abort or rst.
  task automatic disturb(input bit use_rst, output int d0, output int nr_after);
    d0 = done_cnt;
    tick();
    start_addr = 8'h10;
    word_count = 9'd10;
    start      = 1'b1;
    out_ready  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 1'b0;
      if (k == 5) begin
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
      end
    end
    tick();
    rst   = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    nr_after = r_addr.size();
  endtask

  initial begin
    int t0, nb0, nr0, d0, nr_after;

    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // 1: basic 3-word run, ready always high; wrap-around sum = 1
    dmem[0] = 32'h0000_0001;
    dmem[1] = 32'hFFFF_FFFF;
    dmem[2] = 32'h0000_0001;
    run("basic", 0, 3, 0, 0, t0, nb0, nr0, d0);
    check_run("basic", 0, 3, t0, nb0, nr0, 1'b1, 32'h0000_0001);
    check("basic_busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("basic_done_width", 64'(done), 64'd0);
    check("basic_sum_held", 64'(checksum), 64'h1);

    // 2: same data under backpressure 1,0,0,1,...
    run("bp", 0, 3, 1, 0, t0, nb0, nr0, d0);
    check_run("bp", 0, 3, t0, nb0, nr0, 1'b0, 32'h0000_0001);

    // 3: zero-length transfer
    run("zero", 0, 0, 0, 0, t0, nb0, nr0, d0);
    check_run("zero", 0, 0, t0, nb0, nr0, 1'b0, 32'h0);
    check("zero_done_cyc", 64'(done_cyc - t0), 64'd1);

    // 4: address wrap 0xFE, 0xFF, 0x00, 0x01
    dmem[8'hFE] = 32'd10;
    dmem[8'hFF] = 32'd20;
    dmem[8'h00] = 32'd30;
    dmem[8'h01] = 32'd40;
    run("wrap", 8'hFE, 4, 0, 0, t0, nb0, nr0, d0);
    check_run("wrap", 8'hFE, 4, t0, nb0, nr0, 1'b1, 32'd100);

    // 5a: abort mid-transfer
    for (int i = 0; i < 10; i++) dmem[8'h10 + i] = 32'(i + 1);
    disturb(1'b0, d0, nr_after);
    check("abort_busy",  64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_rd_en", 64'(mem_rd_en), 64'd0);
    repeat (5) tick();
    check("abort_no_done",  64'(done_cnt), 64'(d0));
    check("abort_no_reads", 64'(r_addr.size()), 64'(nr_after));

    // 5b: reset mid-transfer
    disturb(1'b1, d0, nr_after);
    check_reset_outputs("midrst");
    repeat (5) tick();
    check("midrst_no_done",  64'(done_cnt), 64'(d0));
    check("midrst_no_reads", 64'(r_addr.size()), 64'(nr_after));

    // 5c: new transfer afterwards completes normally; 1+2+...+10 = 55
    run("rerun", 8'h10, 10, 0, 0, t0, nb0, nr0, d0);
    check_run("rerun", 8'h10, 10, t0, nb0, nr0, 1'b1, 32'd55);

    // 6: start pulsed during RUN is ignored; 1+2+3+4+5 = 15
    run("restart", 8'h10, 5, 0, 3, t0, nb0, nr0, d0);
    check_run("restart", 8'h10, 5, t0, nb0, nr0, 1'b1, 32'd15);
    repeat (6) tick();
    check("restart_one_done", 64'(done_cnt), 64'(d0 + 1));
    check("restart_idle",     64'(busy), 64'd0);

    // Protocol rules observed over the whole run
    check("outstanding_le_2", 64'(ovf_err), 64'd0);
    check("stall_stable",     64'(stall_err), 64'd0);
    check("rd_en_only_run",   64'(rdout_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_readout.md
# dmem_readout

Sequential data-memory readout engine for the single-cycle RISC-V core. On a start command it reads a run of words from a synchronous-read data-memory port and streams them out over a valid/ready interface. It marks the final beat and reports an additive checksum. Benches and debug logic use it to pull results out of data memory through a real port instead of hierarchical peeks; it is the read-side counterpart to memory preloading.

## Interface
- ADDR_W, 8 — word-address width of the memory port; addresses wrap modulo 2^ADDR_W.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- start_addr  input  ADDR_W  first word address, captured with start.
- word_count  input  ADDR_W+1  number of words to read, captured with start; 0 is legal.
- abort  input  1  synchronous flush to IDLE; no done pulse.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse after the final beat is accepted.
- checksum  output  32  sum mod 2^32 of all words sent; held from done until the next accepted start.
- mem_rd_en  output  1  read strobe.
- mem_addr  output  ADDR_W  read address.
- mem_rdata  input  32  read data, valid exactly one cycle after mem_rd_en.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  sink ready.
- out_data  output  32  beat payload.
- out_last  output  1  high on the final beat only.
- out_index  output  ADDR_W+1  0-based beat index.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, word_count>0: capture the inputs, clear checksum, go to RUN.
- IDLE, start=1, word_count=0: go to DONE directly; no reads; checksum=0.
- RUN: issue a read when reads remain and fifo_count + inflight − pop < 2, where pop = out_valid & out_ready in that cycle.
- mem_addr advances by 1 per issued read and wraps from 2^ADDR_W−1 to 0.
- Each returned word enters a 2-entry FIFO.
- out_valid is high whenever the FIFO is non-empty; out_data, out_last and out_index describe the FIFO head.
- Payload, last and index hold stable while out_valid=1 and out_ready=0.
- On each pop: checksum += out_data, and the sent counter increments.
- When the final beat pops, go to DONE.
- DONE lasts one cycle (done=1, busy=0), then the block returns to IDLE.
- abort in RUN or DONE: flush the FIFO, discard any in-flight read, return to IDLE, no done. checksum is then undefined until the next start.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins.

## Timing
- Reset values: busy 0, done 0, out_valid 0, out_last 0, out_data 0, out_index 0, mem_rd_en 0, mem_addr 0, checksum 0, state IDLE, FIFO empty.
- Cycle 0: start is sampled.
- Cycle 1: busy=1, mem_rd_en=1, mem_addr=start_addr.
- Cycle 2: first mem_rdata is returned and written into the FIFO at the end of the cycle.
- Cycle 3: first out_valid.
- With out_ready held at 1: one beat per cycle in cycles 3 … N+2, done in cycle N+3, busy falling in the same cycle.
- Backpressure: at most 2 words are buffered or in flight; no read is issued that could overflow the FIFO; no data is lost or duplicated.
- mem_rd_en is never asserted outside RUN.
- rst mid-transfer: all outputs return to their reset values on the next edge, with no done and no further reads.

## Test plan
- dmem[0..2] = 0x00000001, 0xFFFFFFFF, 0x00000001; start_addr=0, word_count=3, out_ready=1 -> beats 1, 0xFFFFFFFF, 1 in cycles 3–5 with out_index 0,1,2 and out_last only on index 2; done in cycle 6; checksum=0x00000001.
- Same data, out_ready toggling 1,0,0,1,… -> identical beat sequence and checksum; at most 2 reads outstanding; payload stable during stalls.
- word_count=0 -> done pulse in cycle 1; no mem_rd_en; no out_valid; checksum=0.
- ADDR_W=8, start_addr=0xFE, word_count=4 -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01; 4 beats; out_last on the 4th.
- Abort, then rst, mid-transfer: word_count=10 with abort asserted in cycle 5 -> FIFO flushed, IDLE on the next cycle, no done. Rerun and assert rst in cycle 5 -> all outputs at reset values on the next edge. A new start afterwards completes normally.
- start pulsed during RUN -> ignored; the original transfer completes unchanged.
